uart_rx_oversampler: RTL and testbench

- Parametrised successor to the UART RX bit sampler.
- Oversamples the serial line at OSR ticks per bit, driven by an external baud-tick strobe rather than every clock.
- Majority-votes a configurable sample window and emits one decided bit per bit period.
- Adds input synchronisation, false-start rejection, break/held-low lockout and a per-bit noise flag. Sits between the baud generator and the UART RX framing FSM, which drives stop.

---
 rtl/uart_rx_oversampler.sv | 137 +++++++++++++
 tb/tb_uart_rx_oversampler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampling bit sampler: synchronises the serial line, majority-votes a
// window of baud ticks per bit and hands one decided bit per period to the framing FSM.
module uart_rx_oversampler #(
  parameter int OSR    = 16,
  parameter int WIN_LO = 6,
  parameter int WIN_HI = 9,
  parameter int CNT_W  = $clog2(OSR),
  parameter int VOTE_W = $clog2(WIN_HI - WIN_LO + 2)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic rx_in,
  input  logic stop,
  output logic bit_out,
  output logic bit_valid,
  output logic noise,
  output logic start_err,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, START, DATA} state_t;

  state_t              state_q, state_d;
  logic                rx_meta, rx_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VOTE_W-1:0]   ones_q, ones_d, zeros_q, zeros_d;
  logic                armed_q, armed_d;
  logic                bit_out_d, noise_d, bit_valid_d, start_err_d;
  logic                in_win, last_tick;

  assign in_win    = (int'(cnt_q) >= WIN_LO) && (int'(cnt_q) <= WIN_HI);
  assign last_tick = (int'(cnt_q) == OSR - 1);

  // Two-stage synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so the two synchroniser stages really are two clocks apart.
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    zeros_d     = zeros_q;
    armed_d     = armed_q;
    bit_out_d   = bit_out;
    noise_d     = noise;
    bit_valid_d = 1'b0;
    start_err_d = 1'b0;

    if (stop) begin
      // Abort wins over everything; clearing armed forces a fresh high tick before
      // another start is accepted, which locks out a held-low (break) line.
      state_d = IDLE;
      cnt_d   = '0;
      ones_d  = '0;
      zeros_d = '0;
      armed_d = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (armed_q && !rx_s) begin
            state_d = START;
            cnt_d   = '0;
            ones_d  = '0;
            zeros_d = '0;
            armed_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        START, DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (in_win) begin
            if (rx_s) ones_d  = ones_q + 1'b1;
            else      zeros_d = zeros_q + 1'b1;
          end
          // The window ends before OSR-1, so the votes are final on the last tick.
          if (last_tick) begin
            ones_d  = '0;
            zeros_d = '0;
            if (state_q == START) begin
              if (zeros_q > ones_q) begin
                state_d = DATA;
              end else begin
                state_d     = IDLE;
                start_err_d = 1'b1;
              end
            end else begin
              bit_valid_d = 1'b1;
              bit_out_d   = (ones_q > zeros_q);
              noise_d     = (ones_q != '0) && (zeros_q != '0);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      zeros_q   <= '0;
      armed_q   <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      noise     <= 1'b0;
      start_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      zeros_q   <= zeros_d;
      armed_q   <= armed_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      noise     <= noise_d;
      start_err <= start_err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler: per-tick line samples and stop events are
// decoded by a bit-period arithmetic model and compared against the DUT after every tick.
module tb_uart_rx_oversampler;

  localparam int OSR    = 16;
  localparam int WIN_LO = 6;
  localparam int WIN_HI = 9;
  localparam int MAXT   = 700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic rx_in = 1'b1;
  logic stop = 1'b0;
  logic bit_out, bit_valid, noise, start_err, busy;

  uart_rx_oversampler #(
    .OSR(OSR), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rx_in), .stop(stop),
    .bit_out(bit_out), .bit_valid(bit_valid), .noise(noise),
    .start_err(start_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus per tick and expected outputs after each tick.
  bit samp [MAXT];
  bit stp  [MAXT];
  bit e_bv [MAXT];
  bit e_se [MAXT];
  bit e_bit[MAXT];
  bit e_nz [MAXT];
  bit e_bsy[MAXT];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_seg();
    for (int k = 0; k < MAXT; k++) begin
      samp[k] = 1'b1;
      stp[k]  = 1'b0;
    end
  endtask

  task automatic put(input int from, input int len, input bit v);
    for (int k = from; k < from + len && k < MAXT; k++) samp[k] = v;
  endtask

  // Decode the tick stream as bit periods of OSR ticks anchored at the accepted start tick.
  task automatic build_expected(input int n);
    int  i, st, j, p, ones, zeros;
    bit  arm, done, hb, hn;
    for (int k = 0; k < MAXT; k++) begin
      e_bv[k] = 0; e_se[k] = 0; e_bit[k] = 0; e_nz[k] = 0; e_bsy[k] = 0;
    end
    i = 0;
    arm = 0;
    while (i < n) begin
      if (stp[i]) begin
        arm = 0;
        i++;
      end else if (!arm || samp[i]) begin
        if (samp[i]) arm = 1;
        i++;
      end else begin
        st = i;
        arm = 0;
        done = 0;
        e_bsy[st] = 1;
        j = st + 1;
        while (!done && j < n) begin
          if (stp[j]) begin
            done = 1;
          end else if ((j - st) % OSR == 0) begin
            p = (j - st) / OSR - 1;
            ones = 0;
            zeros = 0;
            for (int t = st + 1 + OSR * p + WIN_LO; t <= st + 1 + OSR * p + WIN_HI; t++)
              if (samp[t]) ones++; else zeros++;
            if (p == 0) begin
              if (zeros > ones) e_bsy[j] = 1;
              else begin
                e_se[j] = 1;
                done = 1;
              end
            end else begin
              e_bv[j]  = 1;
              e_bit[j] = (ones > zeros);
              e_nz[j]  = (ones != 0) && (zeros != 0);
              e_bsy[j] = 1;
            end
          end else begin
            e_bsy[j] = 1;
          end
          if (!done) j++;
        end
        i = done ? j + 1 : n;
      end
    end
    hb = 0;
    hn = 0;
    for (int k = 0; k < n; k++) begin
      if (e_bv[k]) begin
        hb = e_bit[k];
        hn = e_nz[k];
      end
      e_bit[k] = hb;
      e_nz[k]  = hn;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    tick  = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bit_out", bit_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_noise", noise, 0);
    check("rst_start_err", start_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One tick every 4 clocks; rx_in is set 3 clocks ahead so rx_s has settled.
  task automatic run_segment(input string name, input int n, input int rst_at);
    build_expected(n);
    for (int i = 0; i < n; i++) begin
      rx_in = samp[i];
      tick  = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      check($sformatf("%s bv_drop@%0d", name, i), bit_valid, 0);
      check($sformatf("%s se_drop@%0d", name, i), start_err, 0);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s arst_bit_out", name), bit_out, 0);
        check($sformatf("%s arst_bit_valid", name), bit_valid, 0);
        check($sformatf("%s arst_noise", name), noise, 0);
        check($sformatf("%s arst_start_err", name), start_err, 0);
        check($sformatf("%s arst_busy", name), busy, 0);
        return;
      end
      repeat (2) @(negedge clk);
      tick = 1'b1;
      stop = stp[i];
      @(negedge clk);
      check($sformatf("%s bv@%0d", name, i), bit_valid, e_bv[i]);
      check($sformatf("%s se@%0d", name, i), start_err, e_se[i]);
      check($sformatf("%s bit@%0d", name, i), bit_out, e_bit[i]);
      check($sformatf("%s noise@%0d", name, i), noise, e_nz[i]);
      check($sformatf("%s busy@%0d", name, i), busy, e_bsy[i]);
    end
    tick = 1'b0;
    stop = 1'b0;
  endtask

  task automatic clean_frame();
    clear_seg();
    put(0, 32, 1);
    put(32, 16, 0);
    put(48, 16, 1);
    put(64, 16, 0);
    put(80, 40, 1);
  endtask

  initial begin
    int n, pos, b;

    do_reset();
    clean_frame();
    run_segment("clean", 120, -1);

    do_reset();
    clear_seg();
    put(32, 3, 0);
    run_segment("false_start", 80, -1);

    do_reset();
    clear_seg();
    put(32, 48, 0);
    samp[55] = 1; samp[56] = 1;
    samp[71] = 1; samp[72] = 1; samp[73] = 1;
    run_segment("noisy", 120, -1);

    do_reset();
    clean_frame();
    stp[64] = 1;
    put(65, 20, 0);
    put(85, 3, 1);
    put(88, 16, 0);
    run_segment("abort", 150, -1);

    do_reset();
    clear_seg();
    put(32, 220, 0);
    stp[50] = 1;
    samp[251] = 1;
    put(252, 20, 0);
    run_segment("break", 300, -1);

    do_reset();
    clean_frame();
    run_segment("reset_mid", 120, 56);

    do_reset();
    clear_seg();
    put(0, 10, 0);
    put(30, 16, 0);
    put(62, 16, 0);
    run_segment("recover", 100, -1);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      clear_seg();
      n = 400;
      pos = 5 + int'($urandom_range(20));
      while (pos < n) begin
        b = int'($urandom_range(1));
        if ($urandom_range(5) == 0) b = 1 - b;
        for (int k = pos; k < pos + OSR && k < n; k++)
          samp[k] = ($urandom_range(11) == 0) ? bit'(1 - b) : bit'(b);
        pos += OSR;
      end
      for (int k = 0; k < n; k++) stp[k] = ($urandom_range(149) == 0);
      run_segment($sformatf("rand%0d", r), n, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
